cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit completion ports.
REQ-002 Parameter DEPTH, default 2: entries in each per-port completion buffer, power of two, >= 2.
REQ-003 Parameter PAYLOAD_W, default 64: width of the opaque completion payload.
REQ-004 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port flush  input  1: synchronous pipeline flush.
REQ-007 Port in_valid  input  NUM_FU: per-port completion valid, sourced from each FU's complete_valid.
REQ-008 Port in_data  input  NUM_FU x PAYLOAD_W: per-port completion payload.
REQ-009 Port in_ready  output  NUM_FU: per-port buffer-not-full indication.
REQ-010 Port cdb_valid  output  1: broadcast valid on the common data bus.
REQ-011 Port cdb_data  output  PAYLOAD_W: broadcast payload.
REQ-012 Port cdb_src  output  clog2(NUM_FU): index of the port that produced the broadcast.

Function
REQ-013 Each port shall own a FIFO of DEPTH entries with read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-014 in_ready[i] shall be high iff count[i] < DEPTH, decoded from registered state only, with no combinational path from in_valid or the grant.
REQ-015 A push on port i shall occur at a rising edge where in_valid[i] && in_ready[i] && !flush; when in_valid[i] is high and in_ready[i] is low, the data shall be dropped, and the FU is responsible for the stall.
REQ-016 Each cycle, at most one non-empty port shall be granted, round-robin: search starts at last_grant+1 and wraps modulo NUM_FU.
REQ-017 The granted head entry shall be popped at the edge, last_grant shall update to the winner, and cdb_valid/cdb_data/cdb_src shall be registered from it, visible the cycle after the grant.
REQ-018 Minimum latency: push at edge E0, broadcast valid during the cycle following edge E1, i.e. 2 edges.
REQ-019 When no port is non-empty, cdb_valid shall be 0 next cycle, cdb_data and cdb_src shall hold their previous values, and last_grant shall be unchanged.
REQ-020 A simultaneous push and pop on one port shall leave count unchanged and preserve FIFO order.
REQ-021 On a full port, a pop in the same cycle shall not enable a push; in_ready reflects the pre-edge count.
REQ-022 Ports not granted shall keep their entries; no entry shall ever be lost or duplicated.
REQ-023 Starvation bound: a non-empty port shall be granted within NUM_FU cycles.
REQ-024 cdb has no backpressure; every registered cdb_valid cycle is one consumed broadcast.
REQ-025 Flush shall set all counts and pointers to 0 and cdb_valid to 0 at the edge, and shall discard any same-cycle pushes and grants.
REQ-026 Flush shall leave last_grant unchanged.
REQ-027 Flush and rst together shall behave as rst.

Reset
REQ-028 On rst, all FIFO counts and pointers shall be 0, cdb_valid 0, cdb_data 0, cdb_src 0 and last_grant NUM_FU-1, so port 0 has first priority.
REQ-029 After rst, in_ready shall be all ones from the first cycle.
REQ-030 rst asserted mid-operation shall discard all buffered entries, with no broadcast in the following cycle.

Verification
REQ-031 After reset, push port 2 with 0xA5 at edge 1 -> cdb_valid=1, cdb_src=2, cdb_data=0xA5 in the cycle after edge 2; cdb_valid=0 thereafter.
REQ-032 Push all 4 ports in one cycle with data 0x10..0x13 -> broadcasts in order src 0,1,2,3 on 4 consecutive cycles; last_grant ends at 3.
REQ-033 Hold in_valid[1] high for 4 cycles with 0x1,0x2,0x3,0x4 and no competing port -> in_ready[1] never drops, since one is popped per cycle; output order is 0x1,0x2,0x3,0x4.
REQ-034 Ports 0 and 1 both continuously valid with DEPTH=2 -> grants alternate 0,1,0,1; the second buffered entry makes in_ready drop when count reaches 2; no data is lost.
REQ-035 Fill port 3 with 2 entries, then assert flush -> next cycle cdb_valid=0, in_ready[3]=1, and no stale data is broadcast later.
REQ-036 Fill ports 0 and 2, then assert rst for 1 cycle -> cdb_valid=0 and all counts are 0; the next push on port 1 broadcasts with src=1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-FU completion FIFOs feeding one registered broadcast
// port, granted round-robin starting after the previous winner.
module cdb_arbiter #(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned PAYLOAD_W = 64,
  localparam int unsigned SRC_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_FU-1:0]               in_valid,
  input  logic [NUM_FU-1:0][PAYLOAD_W-1:0] in_data,
  output logic [NUM_FU-1:0]               in_ready,
  output logic                            cdb_valid,
  output logic [PAYLOAD_W-1:0]            cdb_data,
  output logic [SRC_W-1:0]                cdb_src
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PAYLOAD_W-1:0] mem_q    [NUM_FU][DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q [NUM_FU];
  logic [PTR_W-1:0]     wr_ptr_q [NUM_FU];
  logic [CNT_W-1:0]     count_q  [NUM_FU];
  logic [SRC_W-1:0]     last_grant_q;
  logic                 cdb_valid_q;
  logic [PAYLOAD_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]     cdb_src_q;

  logic [NUM_FU-1:0]    not_empty;
  logic [NUM_FU-1:0]    push;
  logic [NUM_FU-1:0]    pop;
  logic                 gnt_valid;
  logic [SRC_W-1:0]     gnt_idx;
  logic [PAYLOAD_W-1:0] head_data;

  // Ready and occupancy come only from registered counts, so in_ready never
  // depends on in_valid or on this cycle's grant.
  always_comb begin
    in_ready  = '0;
    not_empty = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      in_ready[i]  = count_q[i] < CNT_W'(DEPTH);
      not_empty[i] = count_q[i] != '0;
    end
  end

  always_comb begin
    logic [31:0]      idx;
    logic [SRC_W-1:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_FU; k++) begin
      idx  = (32'(last_grant_q) + k) % NUM_FU;
      cand = SRC_W'(idx);
      if (!gnt_valid && not_empty[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    head_data = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i] = in_valid[i] && in_ready[i] && !flush;
      pop[i]  = gnt_valid && (gnt_idx == SRC_W'(i)) && !flush;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (!rst && push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      last_grant_q <= SRC_W'(NUM_FU - 1);
      cdb_valid_q  <= 1'b0;
      cdb_data_q   <= '0;
      cdb_src_q    <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        count_q[i] <= count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      cdb_valid_q <= gnt_valid;
      if (gnt_valid) begin
        cdb_data_q   <= head_data;
        cdb_src_q    <= gnt_idx;
        last_grant_q <= gnt_idx;
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (defaults: 4 ports, depth 2, 64-bit payload).
module tb_cdb_arbiter;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [3:0]       in_valid;
  logic [3:0][63:0] in_data;
  logic [3:0]       in_ready;
  logic             cdb_valid;
  logic [63:0]      cdb_data;
  logic [1:0]       cdb_src;

  int checks;
  int failures;
  int nxt0, nxt1, exp0, exp1, acc0, acc1, bc0, bc1;
  logic [1:0] exp_rdy;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bcast(input string tag, input logic [1:0] src, input logic [63:0] data);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'd1);
    chk({tag, "_src"}, 64'(cdb_src), 64'(src));
    chk({tag, "_data"}, cdb_data, data);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    tick();
    tick();
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_data", cdb_data, 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'hF);

    // Single push on port 2: two-edge latency, then idle holds data/src.
    rst        = 1'b0;
    in_valid   = 4'b0100;
    in_data[2] = 64'hA5;
    tick();
    in_valid = '0;
    chk("lat_e1_valid", 64'(cdb_valid), 64'd0);
    tick();
    bcast("lat_e2", 2'd2, 64'hA5);
    tick();
    chk("idle_valid", 64'(cdb_valid), 64'd0);
    chk("idle_src_hold", 64'(cdb_src), 64'd2);
    chk("idle_data_hold", cdb_data, 64'hA5);

    // All four ports at once after reset: 0,1,2,3.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = 64'h10 + 64'(i);
    tick();
    in_valid = '0;
    chk("all4_e1_valid", 64'(cdb_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      bcast("all4", 2'(i), 64'h10 + 64'(i));
    end
    tick();
    chk("all4_done", 64'(cdb_valid), 64'd0);

    // last_grant is 3, so port 0 beats port 3.
    in_valid   = 4'b1001;
    in_data[0] = 64'h20;
    in_data[3] = 64'h23;
    tick();
    in_valid = '0;
    tick();
    bcast("lg3_first", 2'd0, 64'h20);
    tick();
    bcast("lg3_second", 2'd3, 64'h23);

    // Streaming on port 1: one push and one pop per cycle keeps it ready.
    for (int k = 0; k < 6; k++) begin
      in_valid   = (k < 4) ? 4'b0010 : 4'b0000;
      in_data[1] = 64'(k + 1);
      if (k < 4) chk("stream_ready", 64'(in_ready[1]), 64'd1);
      tick();
      if (k >= 1 && k <= 4) bcast("stream", 2'd1, 64'(k));
      else if (k == 5) chk("stream_done", 64'(cdb_valid), 64'd0);
    end

    // Ports 0 and 1 contend with depth 2; the FU honours in_ready.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    nxt0 = 'h100; nxt1 = 'h200; exp0 = 'h100; exp1 = 'h200;
    acc0 = 0; acc1 = 0; bc0 = 0; bc1 = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid   = (c < 8) ? 4'b0011 : 4'b0000;
      in_data[0] = 64'(nxt0);
      in_data[1] = 64'(nxt1);
      if (c < 8) begin
        exp_rdy = (c < 2) ? 2'b11 : ((c % 2 == 0) ? 2'b01 : 2'b10);
        chk("rr_ready", 64'(in_ready[1:0]), 64'(exp_rdy));
      end
      if (in_valid[0] && in_ready[0]) begin nxt0++; acc0++; end
      if (in_valid[1] && in_ready[1]) begin nxt1++; acc1++; end
      tick();
      if (c >= 1 && c <= 10) begin
        if ((c - 1) % 2 == 0) begin
          bcast("rr_p0", 2'd0, 64'(exp0));
          exp0++; bc0++;
        end else begin
          bcast("rr_p1", 2'd1, 64'(exp1));
          exp1++; bc1++;
        end
      end else if (c == 11) begin
        chk("rr_done", 64'(cdb_valid), 64'd0);
      end
    end
    chk("rr_acc0", 64'(acc0), 64'd5);
    chk("rr_acc1", 64'(acc1), 64'd5);
    chk("rr_lost0", 64'(bc0), 64'(acc0));
    chk("rr_lost1", 64'(bc1), 64'(acc1));

    // Fill port 3 to two entries (last_grant=1, so port 2 wins first), then flush
    // alongside a push on port 0 that must be discarded.
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) in_data[i] = 64'h30 + 64'(i);
    tick();
    in_valid   = 4'b1000;
    in_data[3] = 64'h34;
    tick();
    bcast("pre_flush", 2'd2, 64'h32);
    chk("full_ready3", 64'(in_ready[3]), 64'd0);
    flush      = 1'b1;
    in_valid   = 4'b0001;
    in_data[0] = 64'hEE;
    tick();
    flush    = 1'b0;
    in_valid = '0;
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_no_stale", 64'(cdb_valid), 64'd0);
    end
    // Flush kept last_grant at 2, so port 3 beats port 0.
    in_valid   = 4'b1001;
    in_data[0] = 64'h40;
    in_data[3] = 64'h43;
    tick();
    in_valid = '0;
    tick();
    bcast("flush_lg_first", 2'd3, 64'h43);
    tick();
    bcast("flush_lg_second", 2'd0, 64'h40);

    // Mid-run reset with ports 0 and 2 occupied.
    in_valid   = 4'b0101;
    in_data[0] = 64'h50;
    in_data[2] = 64'h52;
    tick();
    in_valid = '0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(cdb_valid), 64'd0);
    chk("mid_rst_data", cdb_data, 64'd0);
    chk("mid_rst_src", 64'(cdb_src), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'hF);
    tick();
    chk("mid_rst_empty1", 64'(cdb_valid), 64'd0);
    in_valid   = 4'b0010;
    in_data[1] = 64'h77;
    tick();
    in_valid = '0;
    chk("mid_rst_empty2", 64'(cdb_valid), 64'd0);
    tick();
    bcast("post_rst", 2'd1, 64'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
